// File: rtl/mux2_sel_arbiter_if.sv
// Handshake bundle between the requesters/mux and mux2_sel_arbiter.
// The arbiter binds to the slave modport. The requester/mux side binds to the master modport.
interface mux2_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic y;
    logic s;
    logic grant_a;
    logic grant_b;
    logic busy;
    logic y_q;
    logic y_vld;

    modport master (
        output req_a,
        output req_b,
        output y,
        input  s,
        input  grant_a,
        input  grant_b,
        input  busy,
        input  y_q,
        input  y_vld
    );

    modport slave (
        input  req_a,
        input  req_b,
        input  y,
        output s,
        output grant_a,
        output grant_b,
        output busy,
        output y_q,
        output y_vld
    );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// mux2_sel_arbiter: round-robin arbiter that drives the select of a 2:1 mux.
// - Each grant is held for DWELL sampled cycles.
// - The fed-back mux output y is registered into y_q, and y_vld qualifies each sample.
// - Optional macro MUX_SEL_BREAK_BEFORE_MAKE_EN inserts a grant-free GAP cycle on every
//   handover between channels. s changes on the GAP->SETTLE edge.
module mux2_sel_arbiter #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input logic               clk,
    input logic               rst_n,
    mux2_sel_arbiter_if.slave bus
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CW;

    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("mux2_sel_arbiter: DWELL must be in 1..255");
    end
    if (CNT_SPAN <= 64'(DWELL)) begin : g_bad_cw
        $error("mux2_sel_arbiter: CW too narrow for DWELL");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
`ifdef MUX_SEL_BREAK_BEFORE_MAKE_EN
        ,
        GAP    = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          s_q, s_d;
    logic          ga_q, ga_d;
    logic          gb_q, gb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;   // 1: channel b was served last
    logic          yq_q;
    logic          yvld_q;

    logic          own_req;
    logic          other_req;
    logic          pick_b;

    // The granted channel always matches s, so s identifies the owner.
    assign own_req   = s_q ? bus.req_b : bus.req_a;
    assign other_req = s_q ? bus.req_a : bus.req_b;
    // Pick b when b is the only requester, or when both request and a was served last.
    assign pick_b    = bus.req_b && (!bus.req_a || !last_q);

    // Next-state, next-select and grant decisions.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    s_d     = pick_b;
                    ga_d    = !pick_b;
                    gb_d    = pick_b;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d   = CW'(DWELL - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0 || !own_req) begin
                    last_d = s_q;
                    if (other_req) begin
`ifdef MUX_SEL_BREAK_BEFORE_MAKE_EN
                        ga_d    = 1'b0;
                        gb_d    = 1'b0;
                        state_d = GAP;
`else
                        s_d     = !s_q;
                        ga_d    = s_q;
                        gb_d    = !s_q;
                        state_d = SETTLE;
`endif
                    end else if (own_req) begin
                        state_d = SETTLE;
                    end else begin
                        ga_d    = 1'b0;
                        gb_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef MUX_SEL_BREAK_BEFORE_MAKE_EN
            GAP: begin
                // s still holds the old owner, so the new owner is its complement.
                s_d     = !s_q;
                ga_d    = s_q;
                gb_d    = !s_q;
                state_d = SETTLE;
            end
`endif
            default: begin
                ga_d    = 1'b0;
                gb_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, select, grant, counter and round-robin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            ga_q    <= 1'b0;
            gb_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // y is sampled on each edge that enters or stays in HOLD.
    // y_vld is therefore high exactly during HOLD cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yq_q   <= 1'b0;
            yvld_q <= 1'b0;
        end else begin
            yvld_q <= (state_d == HOLD);
            if (state_d == HOLD) begin
                yq_q <= bus.y;
            end
        end
    end

    assign bus.s       = s_q;
    assign bus.grant_a = ga_q;
    assign bus.grant_b = gb_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.y_q     = yq_q;
    assign bus.y_vld   = yvld_q;

`ifndef SYNTHESIS
    a_grant_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ga_q && gb_q));
    a_vld_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        yvld_q |-> (state_q == HOLD));
    a_s_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(ga_q || gb_q) && (ga_q || gb_q) && (s_q != $past(s_q))) |-> (state_q == SETTLE));
`endif

endmodule
